wt_time_counter: RTL and testbench
==================================

# wt_time_counter

Time-of-day counter for the watch-time (WT) datapath. It divides the system clock to a 1 Hz tick, keeps hours, minutes and seconds as binary counts, and supports a set mode for manual adjustment. It sits directly upstream of the tens/ones digit separators: each 7-bit value output feeds one separator's `NUMBER` input. Every value it drives is within 0..99.

## Interface
- `CLK_FREQ`, default 1000: CLK cycles per second. Must be ≥2. Use 4 in simulation.
- `CLK`  in  1  system clock; the only clock.
- `RST`  in  1  reset. Synchronous, active-high.
- `EN`  in  1  run enable. 0 pauses timekeeping while in run mode.
- `SET_MODE`  in  1  1 = adjust mode. Timekeeping is frozen.
- `SET_SEL`  in  2  field to adjust: 0 = SEC, 1 = MIN, 2 = HOUR, 3 = none.
- `INC`  in  1  single-cycle pulse (already debounced upstream). Adds 1 to the selected field.
- `DEC`  in  1  single-cycle pulse. Subtracts 1 from the selected field.
- `MODE_12H`  in  1  1 = 12-hour display.
- `SEC`  out  7  seconds, 0..59. Registered.
- `MIN`  out  7  minutes, 0..59. Registered.
- `HOUR`  out  7  hours, 0..23. Registered; always 24-hour.
- `HOUR_DISP`  out  7  display hour: 0..23, or 1..12 when `MODE_12H` = 1. Combinational from `HOUR` and `MODE_12H`.
- `PM`  out  1  `HOUR` ≥ 12 and `MODE_12H` = 1. Combinational.
- `TICK`  out  1  one-cycle pulse on each 1 Hz increment. Registered.
- `DAY_WRAP`  out  1  one-cycle pulse when the time rolls over from 23:59:59 to 00:00:00. Registered.

## Operation
- Reset values: `SEC` = `MIN` = `HOUR` = 0, prescaler = 0, `TICK` = 0, `DAY_WRAP` = 0. After reset `HOUR_DISP` is 0 (24-hour mode) or 12 (12-hour mode), and `PM` = 0.
- Priority order: `RST`, then `SET_MODE`, then `EN`.
- Run mode (`SET_MODE` = 0, `EN` = 1):
  - The prescaler counts 0..`CLK_FREQ`-1.
  - At terminal count it returns to 0, asserts `TICK`, and increments `SEC`.
  - `SEC` wraps 59→0 and carries into `MIN`; `MIN` wraps 59→0 and carries into `HOUR`; `HOUR` wraps 23→0.
  - The full rollover 23:59:59→00:00:00 asserts `DAY_WRAP` together with `TICK`.
- Pause (`SET_MODE` = 0, `EN` = 0): the prescaler and all fields hold. No `TICK`.
- Set mode (`SET_MODE` = 1):
  - The prescaler is held at 0. `TICK` and `DAY_WRAP` stay 0.
  - `INC` or `DEC` changes only the `SET_SEL` field, wrapping modulo its range (SEC and MIN 60, HOUR 24). No carry or borrow reaches neighbouring fields.
  - `INC` and `DEC` in the same cycle: no change.
  - `SET_SEL` = 3: `INC` and `DEC` are ignored.
  - `INC` and `DEC` are ignored outside set mode.
- Leaving set mode: the prescaler restarts from 0, so the first tick comes a full `CLK_FREQ` cycles later.
- 12-hour mapping: `HOUR` 0→12, 1..12→unchanged, 13..23→`HOUR`−12. `PM` = 1 for `HOUR` 12..23.
- Width rules: all field arithmetic is 7-bit unsigned. Comparisons use == against the maximum value, never overflow detection. The prescaler is $clog2(`CLK_FREQ`) bits wide.

## Timing
- The first `TICK` after reset deassertion comes on the `CLK_FREQ`-th rising edge. The new `SEC` value is visible in the same cycle as `TICK`.
- Ticks repeat every `CLK_FREQ` cycles while running.
- An `INC` or `DEC` sampled at edge n is reflected in the field at edge n.
- `RST` asserted mid-count: on the next edge all registers take their reset values, including any `TICK` that was pending.
- A `SET_MODE` rise on the edge where the prescaler would reach terminal count suppresses that tick.

## Structure
- A shared package `wt_pkg` holds:
  - `SEC_MAX` = 59, `MIN_MAX` = 59, `HOUR_MAX` = 23;
  - the `SET_SEL` encodings `SEL_SEC`, `SEL_MIN`, `SEL_HOUR`, `SEL_NONE`.
- One sub-module, `wt_mod_counter`, is instantiated three times. It has:
  - parameter `MAX`;
  - inputs `CLK`, `RST`, `CNT_EN` (carry in), `INC`, `DEC`;
  - outputs `VALUE` [6:0] and `CARRY`, a combinational terminal-count-and-`CNT_EN` signal.
- The top level contains the prescaler, the set-mode steering, the `DAY_WRAP` register, and the 12-hour mapping.

## Test plan
All scenarios use `CLK_FREQ` = 4.
- Release reset, `EN` = 1 → `TICK` high only on the 4th edge with `SEC` = 1; then every 4 cycles; after 8 ticks `SEC` = 8.
- Set 23:59:58 in set mode, leave, run → after 2 ticks the time is 00:00:00 with `DAY_WRAP` = 1 for exactly 1 cycle, coincident with `TICK`.
- Set mode, `SET_SEL` = 1, `MIN` = 0, `DEC` → `MIN` = 59 with `HOUR` unchanged; `SET_SEL` = 2, `HOUR` = 23, `INC` → `HOUR` = 0 with no `DAY_WRAP`.
- `INC` and `DEC` together, then `INC` with `SET_SEL` = 3, then `INC` in run mode → no field changes in any case.
- `MODE_12H` = 1 with `HOUR` = 0, 12, 13, 23 → `HOUR_DISP`/`PM` = 12/0, 12/1, 1/1, 11/1; `MODE_12H` = 0 with `HOUR` = 13 → 13/0.
- `RST` pulse at 10:20:30 with the prescaler at 2 → next cycle 00:00:00 and `TICK` = 0; the next `TICK` comes 4 edges after `RST` falls.

Source files
------------

// File: rtl/wt_pkg.sv
// Shared constants, field-select encodings and the 12-hour mapping helper
// for the watch-time datapath.
package wt_pkg;

  localparam logic [6:0] SEC_MAX  = 7'd59;
  localparam logic [6:0] MIN_MAX  = 7'd59;
  localparam logic [6:0] HOUR_MAX = 7'd23;

  typedef enum logic [1:0] {
    SEL_SEC  = 2'd0,
    SEL_MIN  = 2'd1,
    SEL_HOUR = 2'd2,
    SEL_NONE = 2'd3
  } set_sel_e;

  // 0 -> 12, 1..12 unchanged, 13..23 -> hour-12.
  function automatic logic [6:0] hour_to_12h(input logic [6:0] hour);
    logic [6:0] result;
    result = hour;
    if (hour == 7'd0) begin
      result = 7'd12;
    end else if (hour > 7'd12) begin
      result = hour - 7'd12;
    end
    return result;
  endfunction

endpackage

// File: rtl/wt_mod_counter.sv
// Modulo-(MAX+1) counter with carry chaining and independent up/down
// adjustment; counting via CNT_EN takes priority over manual adjustment.
module wt_mod_counter #(
  parameter logic [6:0] MAX = 7'd59
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       CNT_EN,
  input  logic       INC,
  input  logic       DEC,
  output logic [6:0] VALUE,
  output logic       CARRY
);

  logic [6:0] value_reg;
  logic       at_max;
  logic       at_zero;

  assign at_max  = (value_reg == MAX);
  assign at_zero = (value_reg == 7'd0);

  always_ff @(posedge CLK) begin
    if (RST) begin
      value_reg <= 7'd0;
    end else if (CNT_EN) begin
      value_reg <= at_max ? 7'd0 : value_reg + 7'd1;
    end else if (INC && !DEC) begin
      value_reg <= at_max ? 7'd0 : value_reg + 7'd1;
    end else if (DEC && !INC) begin
      value_reg <= at_zero ? MAX : value_reg - 7'd1;
    end
  end

  assign VALUE = value_reg;
  assign CARRY = CNT_EN && at_max;

endmodule

// File: rtl/wt_time_counter.sv
// Time-of-day counter: 1 Hz prescaler, chained SEC/MIN/HOUR counters,
// set-mode steering, day-wrap pulse and 12-hour display mapping.
module wt_time_counter
  import wt_pkg::*;
#(
  parameter int CLK_FREQ = 1000
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic       SET_MODE,
  input  logic [1:0] SET_SEL,
  input  logic       INC,
  input  logic       DEC,
  input  logic       MODE_12H,
  output logic [6:0] SEC,
  output logic [6:0] MIN,
  output logic [6:0] HOUR,
  output logic [6:0] HOUR_DISP,
  output logic       PM,
  output logic       TICK,
  output logic       DAY_WRAP
);

  localparam int PW = $clog2(CLK_FREQ);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

  logic [PW-1:0] presc_reg;
  logic          tick_reg;
  logic          day_wrap_reg;
  logic          run;
  logic          tick_next;
  set_sel_e      sel;

  logic sec_inc, sec_dec, min_inc, min_dec, hour_inc, hour_dec;
  logic sec_carry, min_carry, hour_carry;

  assign run       = !SET_MODE && EN;
  assign tick_next = run && (presc_reg == PRESC_LAST);
  assign sel       = set_sel_e'(SET_SEL);

  // Set mode parks the prescaler at 0 so the first tick after leaving it
  // arrives a full second later.
  always_ff @(posedge CLK) begin
    if (RST) begin
      presc_reg <= '0;
    end else if (SET_MODE) begin
      presc_reg <= '0;
    end else if (EN) begin
      presc_reg <= tick_next ? '0 : presc_reg + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      tick_reg     <= 1'b0;
      day_wrap_reg <= 1'b0;
    end else begin
      tick_reg     <= tick_next;
      day_wrap_reg <= hour_carry;
    end
  end

  // Adjust pulses reach only the selected field, and only in set mode.
  assign sec_inc  = SET_MODE && INC && (sel == SEL_SEC);
  assign sec_dec  = SET_MODE && DEC && (sel == SEL_SEC);
  assign min_inc  = SET_MODE && INC && (sel == SEL_MIN);
  assign min_dec  = SET_MODE && DEC && (sel == SEL_MIN);
  assign hour_inc = SET_MODE && INC && (sel == SEL_HOUR);
  assign hour_dec = SET_MODE && DEC && (sel == SEL_HOUR);

  wt_mod_counter #(.MAX(SEC_MAX)) u_sec (
    .CLK    (CLK),
    .RST    (RST),
    .CNT_EN (tick_next),
    .INC    (sec_inc),
    .DEC    (sec_dec),
    .VALUE  (SEC),
    .CARRY  (sec_carry)
  );

  wt_mod_counter #(.MAX(MIN_MAX)) u_min (
    .CLK    (CLK),
    .RST    (RST),
    .CNT_EN (sec_carry),
    .INC    (min_inc),
    .DEC    (min_dec),
    .VALUE  (MIN),
    .CARRY  (min_carry)
  );

  wt_mod_counter #(.MAX(HOUR_MAX)) u_hour (
    .CLK    (CLK),
    .RST    (RST),
    .CNT_EN (min_carry),
    .INC    (hour_inc),
    .DEC    (hour_dec),
    .VALUE  (HOUR),
    .CARRY  (hour_carry)
  );

  assign TICK      = tick_reg;
  assign DAY_WRAP  = day_wrap_reg;
  assign HOUR_DISP = MODE_12H ? hour_to_12h(HOUR) : HOUR;
  assign PM        = MODE_12H && (HOUR >= 7'd12);

endmodule

// File: tb/tb_wt_time_counter.sv
// Directed bench for wt_time_counter with CLK_FREQ = 4; expected values are
// hand-computed constants checked with immediate assertions.
module tb_wt_time_counter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic       SET_MODE;
  logic [1:0] SET_SEL;
  logic       INC;
  logic       DEC;
  logic       MODE_12H;
  logic [6:0] SEC;
  logic [6:0] MIN;
  logic [6:0] HOUR;
  logic [6:0] HOUR_DISP;
  logic       PM;
  logic       TICK;
  logic       DAY_WRAP;

  int checks = 0;
  int errors = 0;

  wt_time_counter #(.CLK_FREQ(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .SET_MODE  (SET_MODE),
    .SET_SEL   (SET_SEL),
    .INC       (INC),
    .DEC       (DEC),
    .MODE_12H  (MODE_12H),
    .SEC       (SEC),
    .MIN       (MIN),
    .HOUR      (HOUR),
    .HOUR_DISP (HOUR_DISP),
    .PM        (PM),
    .TICK      (TICK),
    .DAY_WRAP  (DAY_WRAP)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse(input logic i, input logic d, input int n);
    repeat (n) begin
      INC = i;
      DEC = d;
      step(1);
      INC = 1'b0;
      DEC = 1'b0;
    end
  endtask

  task automatic chk_time(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"}, 32'(HOUR), 32'(h));
    chk({tag, "_min"},  32'(MIN),  32'(m));
    chk({tag, "_sec"},  32'(SEC),  32'(s));
    $display("%0t %s time %0d:%0d:%0d", $time, tag, HOUR, MIN, SEC);
  endtask

  initial begin
    RST = 1'b1; EN = 1'b0; SET_MODE = 1'b0; SET_SEL = 2'd3;
    INC = 1'b0; DEC = 1'b0; MODE_12H = 1'b0;
    step(2);

    // Reset state
    chk_time("reset", 0, 0, 0);
    chk("reset_tick", 32'(TICK), 32'd0);
    chk("reset_day_wrap", 32'(DAY_WRAP), 32'd0);
    chk("reset_disp24", 32'(HOUR_DISP), 32'd0);
    chk("reset_pm24", 32'(PM), 32'd0);
    MODE_12H = 1'b1;
    #1;
    chk("reset_disp12", 32'(HOUR_DISP), 32'd12);
    chk("reset_pm12", 32'(PM), 32'd0);
    MODE_12H = 1'b0;

    // First tick on the 4th edge, then every 4 cycles
    RST = 1'b0; EN = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      step(1);
      chk($sformatf("first_tick_low_e%0d", e), 32'(TICK), 32'd0);
    end
    step(1);
    chk("first_tick_high", 32'(TICK), 32'd1);
    chk("first_tick_sec", 32'(SEC), 32'd1);
    for (int k = 2; k <= 8; k++) begin
      step(3);
      chk($sformatf("tick%0d_pre_low", k), 32'(TICK), 32'd0);
      step(1);
      chk($sformatf("tick%0d_high", k), 32'(TICK), 32'd1);
      chk($sformatf("tick%0d_sec", k), 32'(SEC), 32'(k));
    end
    chk_time("after_8_ticks", 0, 0, 8);

    // Set 23:59:58: SEC 8 -> 58 via 10 DECs, MIN 0 -> 59, HOUR 0 -> 23
    SET_MODE = 1'b1;
    SET_SEL = 2'd0; pulse(1'b0, 1'b1, 10);
    chk_time("set_sec58", 0, 0, 58);
    SET_SEL = 2'd1; pulse(1'b0, 1'b1, 1);
    chk_time("min_borrow_free", 0, 59, 58);
    SET_SEL = 2'd2; pulse(1'b0, 1'b1, 1);
    chk_time("set_235958", 23, 59, 58);
    chk("set_mode_no_tick", 32'(TICK), 32'd0);

    // Run through midnight
    SET_MODE = 1'b0; SET_SEL = 2'd3;
    step(4);
    chk("wrap_t1_tick", 32'(TICK), 32'd1);
    chk("wrap_t1_day_wrap", 32'(DAY_WRAP), 32'd0);
    chk_time("wrap_t1", 23, 59, 59);
    step(3);
    chk("wrap_t2_pre_day_wrap", 32'(DAY_WRAP), 32'd0);
    step(1);
    chk("wrap_t2_tick", 32'(TICK), 32'd1);
    chk("wrap_t2_day_wrap", 32'(DAY_WRAP), 32'd1);
    chk_time("wrap_t2", 0, 0, 0);
    step(1);
    chk("wrap_after_day_wrap", 32'(DAY_WRAP), 32'd0);
    chk("wrap_after_tick", 32'(TICK), 32'd0);

    // Prescaler is at 1; two more edges put it at terminal count
    step(2);
    SET_MODE = 1'b1;
    step(1);
    chk("setmode_suppress_tick", 32'(TICK), 32'd0);
    chk("setmode_suppress_sec", 32'(SEC), 32'd0);

    // Field wrap without carry/borrow
    SET_SEL = 2'd1; pulse(1'b0, 1'b1, 1);
    chk_time("min_dec_wrap", 0, 59, 0);
    SET_SEL = 2'd2; pulse(1'b0, 1'b1, 1);
    chk("hour_dec_wrap", 32'(HOUR), 32'd23);
    pulse(1'b1, 1'b0, 1);
    chk_time("hour_inc_wrap", 0, 59, 0);
    chk("hour_inc_no_day_wrap", 32'(DAY_WRAP), 32'd0);
    step(1);
    chk("hour_inc_no_day_wrap_late", 32'(DAY_WRAP), 32'd0);

    // Ignored adjustments
    SET_SEL = 2'd0; pulse(1'b1, 1'b1, 1);
    chk_time("inc_dec_together", 0, 59, 0);
    SET_SEL = 2'd3; pulse(1'b1, 1'b0, 1);
    chk_time("sel_none_inc", 0, 59, 0);
    SET_MODE = 1'b0; EN = 1'b1; SET_SEL = 2'd0;
    pulse(1'b1, 1'b0, 1);
    chk_time("run_mode_inc", 0, 59, 0);
    chk("run_mode_inc_tick", 32'(TICK), 32'd0);
    EN = 1'b0;
    step(6);
    chk_time("pause_hold", 0, 59, 0);
    chk("pause_no_tick", 32'(TICK), 32'd0);

    // 12-hour mapping
    SET_MODE = 1'b1; SET_SEL = 2'd2; MODE_12H = 1'b1;
    #1;
    chk("h0_disp", 32'(HOUR_DISP), 32'd12);
    chk("h0_pm", 32'(PM), 32'd0);
    pulse(1'b1, 1'b0, 1);
    chk("h1_disp", 32'(HOUR_DISP), 32'd1);
    chk("h1_pm", 32'(PM), 32'd0);
    pulse(1'b1, 1'b0, 11);
    chk("h12_disp", 32'(HOUR_DISP), 32'd12);
    chk("h12_pm", 32'(PM), 32'd1);
    pulse(1'b1, 1'b0, 1);
    chk("h13_disp", 32'(HOUR_DISP), 32'd1);
    chk("h13_pm", 32'(PM), 32'd1);
    MODE_12H = 1'b0;
    #1;
    chk("h13_disp24", 32'(HOUR_DISP), 32'd13);
    chk("h13_pm24", 32'(PM), 32'd0);
    MODE_12H = 1'b1;
    pulse(1'b1, 1'b0, 10);
    chk("h23_hour", 32'(HOUR), 32'd23);
    chk("h23_disp", 32'(HOUR_DISP), 32'd11);
    chk("h23_pm", 32'(PM), 32'd1);
    MODE_12H = 1'b0;

    // Reset mid-count at 10:20:30: HOUR 23 -> 10, MIN 59 -> 20, SEC 0 -> 30
    pulse(1'b0, 1'b1, 13);
    SET_SEL = 2'd1; pulse(1'b0, 1'b1, 39);
    SET_SEL = 2'd0; pulse(1'b1, 1'b0, 30);
    chk_time("set_102030", 10, 20, 30);
    SET_MODE = 1'b0; EN = 1'b1; SET_SEL = 2'd3;
    step(2);
    chk_time("prescaler_at_2", 10, 20, 30);
    RST = 1'b1;
    step(1);
    chk_time("rst_mid_count", 0, 0, 0);
    chk("rst_mid_tick", 32'(TICK), 32'd0);
    RST = 1'b0;
    step(3);
    chk("rst_release_tick_low", 32'(TICK), 32'd0);
    step(1);
    chk("rst_release_tick_high", 32'(TICK), 32'd1);
    chk_time("rst_release_first_tick", 0, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
